// File: rtl/clock_mode_ctrl_if.sv
// Button, running-time and edit/alarm signals exchanged between the clock
// mode controller (slave) and its environment (master).
interface clock_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [4:0] edit_hours;
    logic [5:0] edit_minutes;
    logic [5:0] edit_seconds;
    logic       time_load;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       blink;

    modport master (
        output btn_mode, btn_left, btn_right, btn_up, btn_down,
        output cur_hours, cur_minutes, cur_seconds,
        input  mode, pos, edit_hours, edit_minutes, edit_seconds,
        input  time_load, alarm_hours, alarm_minutes, blink
    );

    modport slave (
        input  btn_mode, btn_left, btn_right, btn_up, btn_down,
        input  cur_hours, cur_minutes, cur_seconds,
        output mode, pos, edit_hours, edit_minutes, edit_seconds,
        output time_load, alarm_hours, alarm_minutes, blink
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Button-driven time/alarm setting controller: RUN -> SET_TIME -> COMMIT -> SET_ALARM -> RUN,
// with digit editing, idle timeout and a blink output for the edited display.
module clock_mode_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned BLINK_CYCLES   = 25000000
) (
    input logic              clk,
    input logic              reset_n,
    clock_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StSetTime  = 2'd1,
        StCommit   = 2'd2,
        StSetAlarm = 2'd3
    } state_e;

    localparam int unsigned IdleW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TIMEOUT_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        pos_q, pos_d;
    logic [4:0]        edit_h_q, edit_h_d, alarm_h_q, alarm_h_d;
    logic [5:0]        edit_m_q, edit_m_d, alarm_m_q, alarm_m_d;
    logic [5:0]        edit_s_q, edit_s_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic [4:0]        btn, btn_prev_q, ev;
    logic              set_q, set_d;

    // Bit order encodes priority: mode > up > down > left > right.
    assign btn = {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    assign ev  = btn & ~btn_prev_q;

    // Add/subtract 1 or 10 modulo 'modulus' by compare-and-correct in 7 bits.
    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [6:0] modulus,
                                              input logic big, input logic inc);
        logic [6:0] d;
        logic [6:0] r;
        d = big ? 7'd10 : 7'd1;
        if (inc) begin
            r = {1'b0, v} + d;
            if (r >= modulus) r = r - modulus;
        end else if ({1'b0, v} >= d) begin
            r = {1'b0, v} - d;
        end else begin
            r = {1'b0, v} + modulus - d;
        end
        return 6'(r);
    endfunction

    assign set_q = (state_q == StSetTime) || (state_q == StSetAlarm);
    assign set_d = (state_d == StSetTime) || (state_d == StSetAlarm);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        edit_h_d  = edit_h_q;
        edit_m_d  = edit_m_q;
        edit_s_d  = edit_s_q;
        alarm_h_d = alarm_h_q;
        alarm_m_d = alarm_m_q;
        idle_d    = idle_q + 1'b1;
        unique case (state_q)
            StRun: begin
                if (ev[4]) begin
                    state_d  = StSetTime;
                    pos_d    = 3'd0;
                    edit_h_d = (bus.cur_hours > 5'd23) ? 5'd0 : bus.cur_hours;
                    edit_m_d = (bus.cur_minutes > 6'd59) ? 6'd0 : bus.cur_minutes;
                    edit_s_d = (bus.cur_seconds > 6'd59) ? 6'd0 : bus.cur_seconds;
                end
            end
            StSetTime, StSetAlarm: begin
                if (ev[4]) begin
                    if (state_q == StSetTime) begin
                        state_d = StCommit;
                    end else begin
                        alarm_h_d = edit_h_q;
                        alarm_m_d = edit_m_q;
                        state_d   = StRun;
                    end
                end else if (ev[3] || ev[2]) begin
                    idle_d = '0;
                    if (pos_q < 3'd2) begin
                        edit_s_d = step_field(edit_s_q, 7'd60, pos_q[0], ev[3]);
                    end else if (pos_q < 3'd4) begin
                        edit_m_d = step_field(edit_m_q, 7'd60, pos_q[0], ev[3]);
                    end else begin
                        edit_h_d = 5'(step_field({1'b0, edit_h_q}, 7'd24, pos_q[0], ev[3]));
                    end
                end else if (ev[1]) begin
                    idle_d = '0;
                    if (pos_q == 3'd5) pos_d = (state_q == StSetTime) ? 3'd0 : 3'd2;
                    else               pos_d = pos_q + 3'd1;
                end else if (ev[0]) begin
                    idle_d = '0;
                    if (state_q == StSetTime) pos_d = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
                    else                      pos_d = (pos_q == 3'd2) ? 3'd5 : pos_q - 3'd1;
                end else if (idle_q == IdleLast) begin
                    state_d = StRun;
                end
            end
            StCommit: begin
                state_d  = StSetAlarm;
                pos_d    = 3'd2;
                edit_h_d = alarm_h_q;
                edit_m_d = alarm_m_q;
                edit_s_d = 6'd0;
            end
            default: state_d = StRun;
        endcase
        if (state_d != state_q) idle_d = '0;
    end

    // Blink runs only while staying in a set state; entry or exit restarts it low.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (set_q && set_d && (state_d == state_q)) begin
            blink_d = blink_q;
            if (blink_cnt_q == BlinkLast) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            pos_q       <= 3'd0;
            edit_h_q    <= 5'd0;
            edit_m_q    <= 6'd0;
            edit_s_q    <= 6'd0;
            alarm_h_q   <= 5'd0;
            alarm_m_q   <= 6'd0;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            btn_prev_q  <= '1;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            edit_h_q    <= edit_h_d;
            edit_m_q    <= edit_m_d;
            edit_s_q    <= edit_s_d;
            alarm_h_q   <= alarm_h_d;
            alarm_m_q   <= alarm_m_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            btn_prev_q  <= btn;
        end
    end

    assign bus.mode          = state_q;
    assign bus.pos           = pos_q;
    assign bus.edit_hours    = edit_h_q;
    assign bus.edit_minutes  = edit_m_q;
    assign bus.edit_seconds  = edit_s_q;
    assign bus.alarm_hours   = alarm_h_q;
    assign bus.alarm_minutes = alarm_m_q;
    assign bus.time_load     = (state_q == StCommit);
    assign bus.blink         = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: directed scenarios plus randomized buttons,
// all compared every cycle against a behavioural model of the setting rules.
module tb_clock_mode_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned BLINK   = 5;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .BLINK_CYCLES   (BLINK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 RUN, 1 SET_TIME, 2 COMMIT, 3 SET_ALARM.
    int       m_mode, m_pos, m_h, m_m, m_s, m_ah, m_am, m_idle, m_age;
    bit [4:0] m_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_h = 0; m_m = 0; m_s = 0;
        m_ah = 0; m_am = 0; m_idle = 0; m_age = 0;
        m_prev = 5'h1f;
    endtask

    task automatic model_adjust(input bit up);
        int d;
        d = (m_pos % 2 == 1) ? 10 : 1;
        if (m_pos < 2)      m_s = up ? (m_s + d) % 60 : (m_s - d + 60) % 60;
        else if (m_pos < 4) m_m = up ? (m_m + d) % 60 : (m_m - d + 60) % 60;
        else                m_h = up ? (m_h + d) % 24 : (m_h - d + 24) % 24;
    endtask

    task automatic model_step();
        bit [4:0] b;
        bit [4:0] ev;
        b  = {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
        ev = b & ~m_prev;
        m_prev = b;
        case (m_mode)
            0: if (ev[4]) begin
                m_mode = 1;
                m_h = (bus.cur_hours > 23) ? 0 : int'(bus.cur_hours);
                m_m = (bus.cur_minutes > 59) ? 0 : int'(bus.cur_minutes);
                m_s = (bus.cur_seconds > 59) ? 0 : int'(bus.cur_seconds);
                m_pos = 0; m_idle = 0; m_age = 0;
            end
            1, 3: begin
                if (ev[4]) begin
                    if (m_mode == 1) m_mode = 2;
                    else begin m_ah = m_h; m_am = m_m; m_mode = 0; end
                end else if (ev[3] || ev[2]) begin
                    model_adjust(ev[3]);
                    m_idle = 0; m_age++;
                end else if (ev[1]) begin
                    m_pos = (m_mode == 1) ? (m_pos + 1) % 6 : 2 + (m_pos - 2 + 1) % 4;
                    m_idle = 0; m_age++;
                end else if (ev[0]) begin
                    m_pos = (m_mode == 1) ? (m_pos + 5) % 6 : 2 + (m_pos - 2 + 3) % 4;
                    m_idle = 0; m_age++;
                end else if (m_idle == TIMEOUT - 1) begin
                    m_mode = 0;
                end else begin
                    m_idle++; m_age++;
                end
            end
            default: begin
                m_mode = 3; m_h = m_ah; m_m = m_am; m_s = 0;
                m_pos = 2; m_idle = 0; m_age = 0;
            end
        endcase
    endtask

    function automatic logic [34:0] model_vec();
        logic exp_blink;
        exp_blink = (m_mode == 1 || m_mode == 3) ? logic'((m_age / BLINK) % 2) : 1'b0;
        return {2'(m_mode), 3'(m_pos), 5'(m_h), 6'(m_m), 6'(m_s), 5'(m_ah), 6'(m_am),
                logic'(m_mode == 2), exp_blink};
    endfunction

    function automatic logic [34:0] dut_vec();
        return {bus.mode, bus.pos, bus.edit_hours, bus.edit_minutes, bus.edit_seconds,
                bus.alarm_hours, bus.alarm_minutes, bus.time_load, bus.blink};
    endfunction

    task automatic set_btn(input logic [4:0] b);
        {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic press(input logic [4:0] b);
        set_btn(b);
        step();
        set_btn(5'b0);
        step();
    endtask

    localparam logic [4:0] BMode  = 5'b10000;
    localparam logic [4:0] BUp    = 5'b01000;
    localparam logic [4:0] BDown  = 5'b00100;
    localparam logic [4:0] BLeft  = 5'b00010;
    localparam logic [4:0] BRight = 5'b00001;

    initial begin
        logic tl_seen;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        set_btn(5'b0);
        bus.cur_hours = 5'd12; bus.cur_minutes = 6'd34; bus.cur_seconds = 6'd56;
        model_reset();
        #12;
        check("reset", 64'(dut_vec()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Enter SET_TIME copying 12:34:56.
        set_btn(BMode);
        step();
        check("enter_set", {bus.mode, bus.edit_hours, bus.edit_minutes, bus.edit_seconds, bus.pos},
              {2'd1, 5'd12, 6'd34, 6'd56, 3'd0});
        set_btn(5'b0);
        step();
        press(BMode);
        press(BMode);
        check("back_to_run", 64'(bus.mode), 64'd0);

        // Digit arithmetic starting from 23:59:55.
        bus.cur_hours = 5'd23; bus.cur_minutes = 6'd59; bus.cur_seconds = 6'd55;
        press(BMode);
        press(BLeft);
        press(BUp);
        check("sec_tens_up", 64'(bus.edit_seconds), 64'd5);
        repeat (3) press(BLeft);
        press(BUp);
        check("hr_ones_up", 64'(bus.edit_hours), 64'd0);
        press(BLeft);
        press(BDown);
        check("hr_tens_down", 64'(bus.edit_hours), 64'd14);

        // Commit and alarm edit.
        set_btn(BMode);
        step();
        check("commit", {bus.mode, bus.time_load, bus.edit_hours, bus.edit_minutes,
              bus.edit_seconds}, {2'd2, 1'b1, 5'd14, 6'd59, 6'd5});
        set_btn(5'b0);
        step();
        check("alarm_entry", {bus.mode, bus.pos, bus.edit_hours, bus.edit_minutes,
              bus.edit_seconds, bus.time_load}, {2'd3, 3'd2, 5'd0, 6'd0, 6'd0, 1'b0});
        press(BLeft);
        repeat (3) press(BUp);
        press(BLeft);
        repeat (7) press(BUp);
        press(BMode);
        check("alarm_store", {bus.mode, bus.alarm_hours, bus.alarm_minutes},
              {2'd0, 5'd7, 6'd30});

        // Priority and SET_ALARM wrap.
        press(BMode);
        press(BUp | BLeft);
        check("prio_up_left", {bus.pos, bus.edit_seconds}, {3'd0, 6'd56});
        press(BMode);
        press(BRight);
        check("alarm_right_wrap", 64'(bus.pos), 64'd5);
        press(BMode);

        // Idle timeout: 16 cycles in SET_TIME, no load, alarm intact.
        set_btn(BMode);
        step();
        set_btn(5'b0);
        tl_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            tl_seen |= bus.time_load;
        end
        check("pre_timeout", 64'(bus.mode), 64'd1);
        step();
        tl_seen |= bus.time_load;
        check("timeout", {bus.mode, tl_seen, bus.alarm_hours, bus.alarm_minutes},
              {2'd0, 1'b0, 5'd7, 6'd30});

        // Press on the last idle cycle keeps the session alive.
        set_btn(BMode);
        step();
        set_btn(5'b0);
        repeat (15) step();
        set_btn(BUp);
        step();
        check("late_press", 64'(bus.mode), 64'd1);
        set_btn(5'b0);
        step();

        // Reset during COMMIT with buttons held through release.
        set_btn(BMode);
        step();
        check("commit2", 64'(bus.mode), 64'd2);
        reset_n = 1'b0;
        set_btn(BMode | BUp);
        #1;
        check("reset_commit", 64'(dut_vec()), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("held_btn", {bus.mode, bus.edit_hours, bus.edit_minutes, bus.edit_seconds},
              {2'd0, 5'd0, 6'd0, 6'd0});
        set_btn(5'b0);
        step();
        press(BMode);
        check("after_reset_enter", 64'(bus.mode), 64'd1);

        // Randomized buttons and time, busy and quiet phases alternating.
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 300; i++) begin
                logic [4:0] b;
                if (blk % 2 == 0) b = 5'($urandom & $urandom);
                else begin
                    for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 19) == 0);
                end
                set_btn(b);
                if ($urandom_range(0, 7) == 0) begin
                    bus.cur_hours   = 5'($urandom_range(0, 31));
                    bus.cur_minutes = 6'($urandom_range(0, 63));
                    bus.cur_seconds = 6'($urandom_range(0, 63));
                end
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000000, SHALL set the idle cycles (10 s at 100 MHz) after which an edit session is abandoned.
REQ-002 Parameter BLINK_CYCLES, default 25000000, SHALL set the half-period of the blink output in clk cycles.
REQ-003 clk  input  1  SHALL be the single 100 MHz clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 btn_mode, btn_left, btn_right, btn_up, btn_down  input  1 each  SHALL be debounced, synchronous, active-high button levels.
REQ-006 cur_hours  input  5, cur_minutes  input  6, cur_seconds  input  6  SHALL be the running time from the timekeeper.
REQ-007 mode  output  2  SHALL report the state: 0 RUN, 1 SET_TIME, 2 COMMIT, 3 SET_ALARM.
REQ-008 pos  output  3  SHALL select the edited digit: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-009 edit_hours  output  5, edit_minutes  output  6, edit_seconds  output  6  SHALL be the edit registers.
REQ-010 time_load  output  1  SHALL be a one-cycle pulse; the timekeeper loads the edit registers while it is high.
REQ-011 alarm_hours  output  5, alarm_minutes  output  6  SHALL hold the stored alarm time.
REQ-012 blink  output  1  SHALL toggle every BLINK_CYCLES cycles while mode is SET_TIME or SET_ALARM, and SHALL be 0 otherwise.

Function
REQ-013 Each button SHALL be edge-detected against a one-cycle-delayed copy; only a 0->1 transition is an event.
REQ-014 When several events occur in one cycle, only the highest-priority one SHALL be acted on: mode > up > down > left > right; the others SHALL be discarded.
REQ-015 RUN + mode event SHALL go to SET_TIME next cycle, copy cur_* into edit_* and set pos=0; a cur_* value out of range (hours>23, min/sec>59) SHALL be copied as 0.
REQ-016 SET_TIME + mode event SHALL go to COMMIT; COMMIT SHALL assert time_load for exactly that one cycle and go unconditionally to SET_ALARM.
REQ-017 On COMMIT->SET_ALARM, edit_hours/edit_minutes SHALL load alarm_hours/alarm_minutes, edit_seconds SHALL load 0, and pos SHALL load 2.
REQ-018 SET_ALARM + mode event SHALL write edit_hours/edit_minutes into alarm_hours/alarm_minutes and go to RUN.
REQ-019 Events arriving during COMMIT SHALL be discarded.
REQ-020 left SHALL increment pos and right SHALL decrement it, with wrap: in SET_TIME 5->0 and 0->5; in SET_ALARM range 2..5, 5->2 and 2->5.
REQ-021 up/down SHALL add/subtract 1 (even pos) or 10 (odd pos) to the selected field, modulo 60 for sec/min and modulo 24 for hours.
REQ-022 Wrap examples: 55+10=5, 59+1=0, 3-10=53, 0-1=59, hours 20+10=6, hours 5-10=19, hours 23+1=0.
REQ-023 Arithmetic SHALL use widths sufficient that no intermediate overflow occurs; no division or modulo operators are required, only compare-and-correct.
REQ-024 An idle counter SHALL clear on entry to SET_TIME/SET_ALARM and on every accepted event; reaching TIMEOUT_CYCLES-1 in either set state SHALL return to RUN with no time_load and no alarm write.
REQ-025 If a timeout and an accepted event coincide, the event SHALL win and the counter SHALL clear.
REQ-026 In RUN, edit_* SHALL hold their last values and up/down/left/right events SHALL be ignored.
REQ-027 The blink counter SHALL restart with blink=0 on each entry to a set state.

Reset
REQ-028 reset_n low SHALL immediately force mode=RUN, pos=0, edit_*=0, time_load=0, alarm_*=0, blink=0, and clear all counters, including in mid-session or during COMMIT.
REQ-029 The delayed button copies SHALL reset to 1, so a button held through reset release produces no event until it is released and pressed again.

Verification
REQ-030 cur=12:34:56, press mode -> next cycle mode=1, edit=12:34:56, pos=0.
REQ-031 SET_TIME with edit=23:59:55, pos=1, press up -> edit_seconds=5; pos=4, up -> edit_hours=0; pos=5, down -> edit_hours=14.
REQ-032 Second mode press -> mode=2 for one cycle with time_load=1 and edit=load value, then mode=3, pos=2, edit=alarm value:00; edit to 07:30, mode -> alarm=07:30, mode=0.
REQ-033 TIMEOUT_CYCLES=16: enter SET_TIME, no presses -> RUN after 16 cycles, time_load never asserted, alarm unchanged; a press on cycle 15 -> still in SET_TIME.
REQ-034 up and left in the same cycle -> only up applied, pos unchanged; right at pos=2 in SET_ALARM -> pos=5.
REQ-035 reset_n low during COMMIT -> time_load drops immediately, all outputs at reset values; btn_up held across release -> no increment.
